regfile_write_arbiter: RTL and testbench

Shares the single register-file write port among NREQ result producers: ALU, FPU and load unit in the default build. Each cycle, one pending write request is granted using round-robin priority. The granted address and data are registered and driven onto the write port one cycle later. The block sits between the execution units' writeback outputs and the `register`-based register file, and owns that file's `enable` and `inp` selection.

---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 tb/tb_regfile_write_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the execution units and the register-file write arbiter.
// The slave modport is the arbiter's view; master is the producer/register-file side.
interface regfile_write_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 3
);
    logic                     stall;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*WIDTH-1:0]    req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [WIDTH-1:0]         wr_data;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ producers.
// Grant is combinational; the winning address/data are registered onto the write port.
module regfile_write_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;

    logic              w_gnt_vld;
    logic [PTR_W-1:0]  w_gnt;
    logic [NREQ-1:0]   w_ready;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_data;
    logic [PTR_W-1:0]  w_ptr_nxt;

    // Walk downward from the farthest offset so the nearest valid index at/after ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = PTR_W'(idx);
            end
        end
        // Reset forces ready low even before the first edge sees rstn.
        if (bus.stall || !rstn) w_gnt_vld = 1'b0;
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == PTR_W'(i)) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_ready
        assign w_ready[i] = w_gnt_vld && (w_gnt == PTR_W'(i));
    end

    assign w_ptr_nxt = (w_gnt == PTR_W'(NREQ - 1)) ? '0 : w_gnt + PTR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // Register 0 is hard-wired: the write is consumed but never enabled.
            r_wr_en <= w_gnt_vld && (w_sel_addr != '0);
            if (w_gnt_vld) begin
                r_ptr     <= w_ptr_nxt;
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed table, reset/round-robin
// sequences and randomized traffic against a transaction-level reference model.
module tb_regfile_write_arbiter;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREQ   = 3;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    regfile_write_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREQ(NREQ)) bus();

    regfile_write_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREQ(NREQ)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the write port must show next, plus the fairness pointer.
    int                m_ptr;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [WIDTH-1:0]  m_data;

    typedef struct {
        logic                   st;
        logic [NREQ-1:0]        v;
        logic [NREQ*ADDR_W-1:0] a;
        logic [NREQ*WIDTH-1:0]  d;
        logic [NREQ-1:0]        rdy;
        logic                   en;
        logic [ADDR_W-1:0]      wa;
        logic [WIDTH-1:0]       wd;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One cycle: drive at negedge, compare, then advance the model across the next posedge.
    task automatic cyc(input logic st, input logic [NREQ-1:0] v,
                       input logic [NREQ*ADDR_W-1:0] a, input logic [NREQ*WIDTH-1:0] d,
                       output int g);
        logic [NREQ-1:0] exp_rdy;
        int i;
        @(negedge clk);
        bus.stall     = st;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        g = -1;
        if (!st) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (v[i] && g < 0) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("wr_en",     64'(bus.wr_en),     64'(m_en));
        chk("wr_addr",   64'(bus.wr_addr),   64'(m_addr));
        chk("wr_data",   64'(bus.wr_data),   64'(m_data));
        if (g >= 0) begin
            m_addr = a[g*ADDR_W +: ADDR_W];
            m_data = d[g*WIDTH +: WIDTH];
            m_en   = (m_addr != 0);
            m_ptr  = (g + 1) % NREQ;
        end else begin
            m_en = 1'b0;
        end
    endtask

    initial begin
        logic [NREQ*ADDR_W-1:0] a3;
        logic [NREQ*WIDTH-1:0]  d3;
        logic [NREQ-1:0]        pv;
        logic [NREQ*ADDR_W-1:0] pa;
        logic [NREQ*WIDTH-1:0]  pd;
        int g;
        tests = 0;
        fails = 0;

        a3 = {5'd3, 5'd2, 5'd1};
        d3 = {32'hA2, 32'hA1, 32'hA0};
        tbl[0]  = '{1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 3'b111, a3, d3, 3'b010, 1'b1, 5'd2, 32'hA1};
        tbl[3]  = '{1'b0, 3'b111, a3, d3, 3'b100, 1'b1, 5'd3, 32'hA2};
        tbl[4]  = '{1'b0, 3'b111, a3, d3, 3'b001, 1'b1, 5'd1, 32'hA0};
        tbl[5]  = '{1'b0, 3'b101, a3, d3, 3'b100, 1'b1, 5'd3, 32'hA2};
        tbl[6]  = '{1'b0, 3'b101, a3, d3, 3'b001, 1'b1, 5'd1, 32'hA0};
        tbl[7]  = '{1'b1, 3'b111, a3, d3, 3'b000, 1'b0, 5'd1, 32'hA0};
        tbl[8]  = '{1'b1, 3'b111, a3, d3, 3'b000, 1'b0, 5'd1, 32'hA0};
        tbl[9]  = '{1'b1, 3'b111, a3, d3, 3'b000, 1'b0, 5'd1, 32'hA0};
        tbl[10] = '{1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 3'b010, 1'b0, 5'd0, 32'h1234};
        tbl[11] = '{1'b0, 3'b111, {5'd9, 5'd8, 5'd7}, {32'hB2, 32'hB1, 32'hB0}, 3'b100, 1'b1, 5'd9, 32'hB2};

        // Reset state, with requests already present to prove ready is forced low.
        rstn          = 1'b0;
        bus.stall     = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = a3;
        bus.req_data  = d3;
        model_reset();
        #12;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        @(negedge clk);
        bus.req_valid = '0;
        rstn = 1'b1;

        // Directed table: ready this cycle, write port in the following cycle.
        for (int r = 0; r < 12; r++) begin
            cyc(tbl[r].st, tbl[r].v, tbl[r].a, tbl[r].d, g);
            chk($sformatf("tbl%0d_rdy", r), 64'(bus.req_ready), 64'(tbl[r].rdy));
            if (r > 0) begin
                chk($sformatf("tbl%0d_en", r - 1), 64'(bus.wr_en), 64'(tbl[r-1].en));
                chk($sformatf("tbl%0d_wa", r - 1), 64'(bus.wr_addr), 64'(tbl[r-1].wa));
                chk($sformatf("tbl%0d_wd", r - 1), 64'(bus.wr_data), 64'(tbl[r-1].wd));
            end
        end
        cyc(1'b0, 3'b000, '0, '0, g);
        chk("tbl11_en", 64'(bus.wr_en), 64'(tbl[11].en));
        chk("tbl11_wa", 64'(bus.wr_addr), 64'(tbl[11].wa));
        chk("tbl11_wd", 64'(bus.wr_data), 64'(tbl[11].wd));

        // Asynchronous reset mid-cycle while a write is on the port.
        cyc(1'b0, 3'b001, {5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'hCAFEF00D}, g);
        @(negedge clk);
        bus.req_valid = 3'b111;
        #1;
        chk("pre_rst_wr_en", 64'(bus.wr_en), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("mid_rst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        model_reset();
        @(negedge clk);
        bus.req_valid = '0;
        rstn = 1'b1;

        // Round-robin from ptr 0 with everyone valid.
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 3'b111, a3, d3, g);
            chk($sformatf("rr_grant%0d", k), 64'(g), 64'(k % NREQ));
        end

        // Randomized traffic; requesters hold their request until it is consumed.
        pv = '0;
        pa = '0;
        pd = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
                    pv[i] = 1'b1;
                    pa[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
                    pd[i*WIDTH +: WIDTH]   = $urandom;
                end
            end
            cyc($urandom_range(0, 3) == 0, pv, pa, pd, g);
            if (g >= 0) pv[g] = 1'b0;
        end
        cyc(1'b0, 3'b000, '0, '0, g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
